usb_rx_unstuff: RTL and testbench

- Receive front end that sits directly upstream of the packet decoder.
- Samples the USB differential line (dp/dm) at one sample per bit time and NRZI-decodes it.
- Checks SYNC, removes stuffed bits, detects EOP, and buffers the whole packet.
- Replays the packet to the decoder as one gap-free bstr/bstr_avail burst followed by a bstr_done pulse. Replay is required because the decoder's bit counter restarts whenever bstr_avail drops.

---
 rtl/usb_rx_unstuff.sv | 177 +++++++++++++++++
 tb/tb_usb_rx_unstuff.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_unstuff.sv
// USB receive front end: NRZI decode, SYNC check, bit unstuffing and EOP detection.
// A whole packet is buffered, then replayed to the decoder as one gap-free burst.
module usb_rx_unstuff #(
    parameter int MAX_BITS = 128,
    parameter int CW       = 7
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          dp,
    input  logic          dm,
    output logic          bstr,
    output logic          bstr_avail,
    output logic          bstr_done,
    output logic [CW-1:0] bit_count,
    output logic          rx_err
);

    // Pointers carry one extra bit so a completely full buffer (wr_ptr == MAX_BITS) is representable.
    localparam int PW = CW + 1;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        EOP1,
        EOP2,
        REPLAY,
        DONE,
        ERR
    } state_t;

    state_t        state_q, state_d;
    logic          prev_q, prev_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0]    ones_q, ones_d;
    logic          jseen_q, jseen_d;
    logic          rx_err_q;
    logic          store_q [MAX_BITS];

    logic isJ, isK, isSe0, isSe1;
    logic rxBit, takeBit, wrEn;

    assign isJ   =  dp & ~dm;
    assign isK   = ~dp &  dm;
    assign isSe0 = ~dp & ~dm;
    assign isSe1 =  dp &  dm;
    // prev_q holds the dp level of the last J/K, so an unchanged line decodes as 1.
    assign rxBit = (dp == prev_q);

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ones_d   = ones_q;
        jseen_d  = jseen_q;
        takeBit  = 1'b0;
        wrEn     = 1'b0;

        case (state_q)
            IDLE: begin
                if (isK) begin
                    state_d = RECV;
                    takeBit = 1'b1;
                end else if (isSe1) begin
                    state_d = ERR;
                end
            end
            RECV: begin
                if (isSe0) begin
                    state_d = EOP1;
                end else if (isSe1) begin
                    state_d = ERR;
                end else begin
                    takeBit = 1'b1;
                end
            end
            EOP1: state_d = isSe0 ? EOP2 : ERR;
            EOP2: state_d = (isJ && (wr_ptr_q >= PW'(16))) ? REPLAY : ERR;
            REPLAY: begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                if (rd_ptr_q == wr_ptr_q - PW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d  = IDLE;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                ones_d   = '0;
                prev_d   = 1'b1;
            end
            ERR: begin
                if (isJ) begin
                    if (jseen_q) begin
                        state_d  = IDLE;
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                        ones_d   = '0;
                        prev_d   = 1'b1;
                        jseen_d  = 1'b0;
                    end else begin
                        jseen_d = 1'b1;
                    end
                end else begin
                    jseen_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Decoded bit handling: SYNC pattern, stuffed-bit removal, then overflow guard.
        if (takeBit) begin
            prev_d = dp;
            if (wr_ptr_q < PW'(8)) begin
                if (rxBit != (wr_ptr_q == PW'(7))) begin
                    state_d = ERR;
                end else begin
                    wrEn = 1'b1;
                end
            end else if (ones_q == 3'd6) begin
                if (rxBit) begin
                    state_d = ERR;
                end else begin
                    ones_d = '0;
                end
            end else if (wr_ptr_q == PW'(MAX_BITS)) begin
                state_d = ERR;
            end else begin
                wrEn = 1'b1;
            end
            if (wrEn) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                ones_d   = rxBit ? ones_q + 3'd1 : 3'd0;
            end
        end

        if ((state_d == ERR) && (state_q != ERR)) begin
            jseen_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= IDLE;
            prev_q   <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ones_q   <= '0;
            jseen_q  <= 1'b0;
            rx_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ones_q   <= ones_d;
            jseen_q  <= jseen_d;
            rx_err_q <= (state_d == ERR) && (state_q != ERR);
        end
    end

    // Packet storage needs no reset: only bits below wr_ptr are ever read back.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            store_q[wr_ptr_q[CW-1:0]] <= rxBit;
        end
    end

    assign bstr_avail = (state_q == REPLAY);
    assign bstr       = bstr_avail & store_q[rd_ptr_q[CW-1:0]];
    assign bstr_done  = (state_q == DONE);
    // A completely full buffer wraps the CW-bit count to zero.
    assign bit_count  = wr_ptr_q[CW-1:0];
    assign rx_err     = rx_err_q;

endmodule

// File: tb/tb_usb_rx_unstuff.sv
// Randomized scoreboard bench for usb_rx_unstuff: a transmitter-side model builds
// stuffed NRZI line traffic and queues the replay/error events the receiver must produce.
module tb_usb_rx_unstuff;

    localparam int MAX_BITS = 128;
    localparam int CW       = 7;
    localparam logic [1:0] LJ   = 2'b10;
    localparam logic [1:0] LK   = 2'b01;
    localparam logic [1:0] LSE0 = 2'b00;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          dp, dm;
    logic          bstr, bstr_avail, bstr_done, rx_err;
    logic [CW-1:0] bit_count;

    usb_rx_unstuff #(.MAX_BITS(MAX_BITS), .CW(CW)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .dp         (dp),
        .dm         (dm),
        .bstr       (bstr),
        .bstr_avail (bstr_avail),
        .bstr_done  (bstr_done),
        .bit_count  (bit_count),
        .rx_err     (rx_err)
    );

    always #5 clk = ~clk;

    // kind: 0 replayed bit, 1 done pulse, 2 error pulse; cyc is the cycle it must appear in.
    typedef struct {
        int kind;
        int val;
        int cnt;
        int cyc;
    } exp_t;

    exp_t expQ[$];
    bit   pkt[$];
    int   cyc = 0;
    int   lastCyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   monKind;
    exp_t monE;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one line symbol; it is sampled by the DUT on the next rising edge.
    task automatic drive(input logic [1:0] s);
        {dp, dm} = s;
        lastCyc  = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic pushErr();
        expQ.push_back('{2, 0, 0, lastCyc + 1});
    endtask

    task automatic recover();
        drive(LK);
        drive(LJ);
        drive(LJ);
    endtask

    task automatic startPkt();
        pkt.delete();
        for (int i = 0; i < 7; i++) pkt.push_back(1'b0);
        pkt.push_back(1'b1);
    endtask

    task automatic addByte(input bit [7:0] v);
        for (int i = 7; i >= 0; i--) pkt.push_back(v[i]);
    endtask

    task automatic addRand(input int n);
        for (int i = 0; i < n; i++) pkt.push_back($urandom_range(0, 3) != 0);
    endtask

    // mode 0: normal EOP; 1: first stuffed bit sent as 1; 2: single-SE0 EOP; 3: reset during replay
    task automatic applyStimulus(input int mode);
        logic level;
        int   run;
        int   stored;
        bit   kept[$];
        level  = 1'b1;
        run    = 0;
        stored = 0;
        for (int i = 0; i < pkt.size(); i++) begin
            if (i >= 8 && run == 6) begin
                if (mode == 1) begin
                    drive(level ? LJ : LK);
                    pushErr();
                    recover();
                    return;
                end
                level = ~level;
                drive(level ? LJ : LK);
                run = 0;
            end
            level = pkt[i] ? level : ~level;
            drive(level ? LJ : LK);
            if ((i < 8 && pkt[i] != (i == 7)) || stored == MAX_BITS) begin
                pushErr();
                recover();
                return;
            end
            kept.push_back(pkt[i]);
            stored++;
            run = pkt[i] ? run + 1 : 0;
        end
        if (mode == 2) begin
            drive(LSE0);
            drive(LJ);
            pushErr();
            recover();
            return;
        end
        drive(LSE0);
        drive(LSE0);
        drive(LJ);
        if (stored < 16) begin
            pushErr();
            recover();
            return;
        end
        for (int i = 0; i < stored; i++) begin
            expQ.push_back('{0, int'(kept[i]), stored % (1 << CW), lastCyc + 1 + i});
        end
        expQ.push_back('{1, 0, stored % (1 << CW), lastCyc + 1 + stored});
        if (mode == 3) begin
            repeat (5) drive(LJ);
            rst_b = 1'b0;
            expQ.delete();
            #1;
            checkOutput("abort bstr_avail", bstr_avail, 0);
            checkOutput("abort bstr", bstr, 0);
            checkOutput("abort bstr_done", bstr_done, 0);
            checkOutput("abort bit_count", bit_count, 0);
            checkOutput("abort rx_err", rx_err, 0);
            #1;
            rst_b = 1'b1;
            @(posedge clk);
            #1;
            repeat (3) drive(LJ);
            return;
        end
        repeat (stored + 2) drive(LJ);
    endtask

    // Monitor: every output event must match the head of the expected queue.
    always @(negedge clk) begin
        if (bstr_avail || bstr_done || rx_err) begin
            monKind = bstr_avail ? 0 : (bstr_done ? 1 : 2);
            if (expQ.size() == 0) begin
                checkOutput("unexpected output event kind", monKind, -1);
            end else begin
                monE = expQ.pop_front();
                checkOutput("event kind", monKind, monE.kind);
                checkOutput("event cycle", cyc, monE.cyc);
                if (monE.kind == 0) begin
                    checkOutput("bstr", bstr, monE.val);
                end else begin
                    checkOutput("bstr idle", bstr, 0);
                end
                if (monE.kind != 2) begin
                    checkOutput("bit_count", bit_count, monE.cnt);
                end
            end
        end
    end

    initial begin
        rst_b = 1'b0;
        {dp, dm} = LJ;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset bstr", bstr, 0);
        checkOutput("reset bstr_avail", bstr_avail, 0);
        checkOutput("reset bstr_done", bstr_done, 0);
        checkOutput("reset bit_count", bit_count, 0);
        checkOutput("reset rx_err", rx_err, 0);
        rst_b = 1'b1;
        repeat (2) drive(LJ);

        startPkt(); addByte(8'b01001011); applyStimulus(0);
        startPkt(); addByte(8'b11111000); applyStimulus(0);
        startPkt(); addByte(8'b11111000); applyStimulus(1);
        pkt.delete(); addByte(8'b00000010); applyStimulus(0);
        startPkt(); pkt.push_back(1'b0); pkt.push_back(1'b1);
        pkt.push_back(1'b0); pkt.push_back(1'b0); applyStimulus(0);
        startPkt(); addByte(8'b01001011); applyStimulus(2);
        startPkt(); addRand(MAX_BITS + 1 - 8); applyStimulus(0);
        startPkt(); addRand(40); applyStimulus(3);
        startPkt(); addByte(8'b01001011); applyStimulus(0);

        for (int n = 0; n < 25; n++) begin
            startPkt();
            addRand($urandom_range(8, 110));
            applyStimulus(($urandom_range(0, 4) == 0) ? 1 : 0);
            repeat ($urandom_range(0, 4)) drive(LJ);
        end

        for (int i = 0; i < 400 && expQ.size() != 0; i++) @(posedge clk);
        checkOutput("pending expected events", expQ.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
